// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Merges single-cycle ALU results and late-returning load data onto the single
//   write port of register_file. Loads are buffered in a FIFO; a non-r0 ALU
//   result always wins the port; an ALU write kills every queued load that
//   targets the same register; writes to r0 are filtered.
//
//   Optional feature macro: WB_LOAD_EXTEND_EN
//     defined   - byte/half extraction and sign/zero extension applied at drain
//     undefined - load data written unmodified; size/sign/offset ports ignored
//
// Ports
//   clock_i               system clock, all state on rising edge
//   reset_n_i             synchronous active-low reset
//   alu_valid_i/addr/data ALU result (no backpressure)
//   load_valid_i/ready_o  load return handshake
//   load_addr_i/data_i    load destination and raw aligned word
//   load_size_i           00 byte, 01 half, 10/11 word
//   load_signed_i         1 sign-extend, 0 zero-extend
//   load_byte_off_i       byte offset within the word
//   register_write_*_o    registered write port to register_file
//   pending_o             queue holds at least one entry
module writeback_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic [1:0]            load_size_i,
  input  logic                  load_signed_i,
  input  logic [1:0]            load_byte_off_i,
  output logic [ADDR_WIDTH-1:0] register_write_addr_o,
  output logic [DATA_WIDTH-1:0] register_write_data_o,
  output logic                  register_write_o,
  output logic                  pending_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] q_addr  [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_data  [QUEUE_DEPTH];
  logic                  q_valid [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  alu_hit, accept, store, deq;
  logic                  wr_n;
  logic [ADDR_WIDTH-1:0] waddr_n;
  logic [DATA_WIDTH-1:0] wdata_n, head_data;

`ifdef WB_LOAD_EXTEND_EN
  logic [1:0] q_size [QUEUE_DEPTH];
  logic       q_sgn  [QUEUE_DEPTH];
  logic [1:0] q_off  [QUEUE_DEPTH];

  function automatic logic [DATA_WIDTH-1:0] extend(
    input logic [DATA_WIDTH-1:0] w,
    input logic [1:0]            sz,
    input logic                  sg,
    input logic [1:0]            off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    // Halfword selection uses off[1] only; off[0] is ignored.
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   extend = {{(DATA_WIDTH-8){sg & b[7]}}, b};
      2'b01:   extend = {{(DATA_WIDTH-16){sg & h[15]}}, h};
      default: extend = w;
    endcase
  endfunction

  assign head_data = extend(q_data[rd_ptr], q_size[rd_ptr], q_sgn[rd_ptr], q_off[rd_ptr]);
`else
  logic ext_unused;
  assign ext_unused = ^{load_size_i, load_signed_i, load_byte_off_i};
  assign head_data  = q_data[rd_ptr];
`endif

  // Ready and pending depend only on registered count.
  assign load_ready_o = (count != CNT_W'(QUEUE_DEPTH));
  assign pending_o    = (count != '0);

  assign alu_hit = alu_valid_i && (alu_addr_i != '0);
  assign accept  = load_valid_i && load_ready_o;
  assign store   = accept && (load_addr_i != '0);
  assign deq     = !alu_hit && (count != '0);

  always_comb begin
    wr_n    = 1'b0;
    waddr_n = '0;
    wdata_n = '0;
    if (alu_hit) begin
      wr_n    = 1'b1;
      waddr_n = alu_addr_i;
      wdata_n = alu_data_i;
    end else if (deq && q_valid[rd_ptr]) begin
      wr_n    = 1'b1;
      waddr_n = q_addr[rd_ptr];
      wdata_n = head_data;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      count                 <= '0;
      register_write_o      <= 1'b0;
      register_write_addr_o <= '0;
      register_write_data_o <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) q_valid[i] <= 1'b0;
    end else begin
      register_write_o      <= wr_n;
      register_write_addr_o <= waddr_n;
      register_write_data_o <= wdata_n;
      // The ALU instruction is younger than every queued load, so matching
      // entries are stale; they stay in the FIFO and drain with no strobe.
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++)
        if (alu_hit && q_valid[i] && (q_addr[i] == alu_addr_i)) q_valid[i] <= 1'b0;
      if (store) begin
        q_valid[wr_ptr] <= !(alu_hit && (load_addr_i == alu_addr_i));
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(store) - CNT_W'(deq);
    end
  end

  // Payload storage needs no reset; occupancy is governed by count.
  always_ff @(posedge clock_i) begin
    if (store) begin
      q_addr[wr_ptr] <= load_addr_i;
      q_data[wr_ptr] <= load_data_i;
`ifdef WB_LOAD_EXTEND_EN
      q_size[wr_ptr] <= load_size_i;
      q_sgn[wr_ptr]  <= load_signed_i;
      q_off[wr_ptr]  <= load_byte_off_i;
`endif
    end
  end

endmodule
